// File: rtl/alu181_pkg.sv
// Shared encodings for the 74181 nibble sequencer: FSM states, nibble width and
// the S/M function codes the benches use.
package alu181_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [3:0] AluSAdd = 4'b1001;
  localparam logic       AluMAdd = 1'b0;
  localparam logic [3:0] AluSSub = 4'b0110;
  localparam logic       AluMSub = 1'b0;
  localparam logic [3:0] AluSAnd = 4'b1011;
  localparam logic       AluMAnd = 1'b1;

endpackage

// File: rtl/alu74181.sv
// Behavioural 4-bit 74181 slice (active-high data, active-low carries). It sits
// beside the sequencer in the wrapper and behind its alu_* ports.
module alu74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cnb,
  output logic [3:0] f,
  output logic       cn4b,
  output logic       aeb
);

  logic [3:0] op1;
  logic [3:0] op2;
  logic [4:0] sum;

  // Every arithmetic function of the part is op1 + op2 + carry; logic mode
  // is the carry-free complement of the same half-sum.
  always_comb begin
    op1  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    op2  = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum  = {1'b0, op1} + {1'b0, op2} + {4'b0000, ~cnb};
    f    = m ? ~(op1 ^ op2) : sum[3:0];
    cn4b = ~sum[4];
    aeb  = &f;
  end

endmodule

// File: rtl/alu181_nibble_sequencer.sv
// Runs WIDTH-bit operations through one external 4-bit 74181 slice, one nibble
// per clock LSB first, chaining carry and AND-ing the per-nibble A=B flags.
module alu181_nibble_sequencer
  import alu181_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [3:0]         req_s,
  input  logic               req_m,
  input  logic               req_cnb,
  output logic [NibbleW-1:0] alu_a,
  output logic [NibbleW-1:0] alu_b,
  output logic [3:0]         alu_s,
  output logic               alu_m,
  output logic               alu_cnb,
  input  logic [NibbleW-1:0] alu_f,
  input  logic               alu_cn4b,
  input  logic               alu_aeb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_f,
  output logic               rsp_cn4b,
  output logic               rsp_aeb,
  output logic               busy
);

  localparam int unsigned NIBBLES = WIDTH / NibbleW;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NibbleW) != 0 || WIDTH < NibbleW) begin : g_bad_width
    $error("alu181_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, f_q;
  logic [3:0]        s_q;
  logic              m_q, carry_q, aeb_q;
  logic [IdxW-1:0]   idx_q;
  logic              cn4b_q, rsp_aeb_q;
  logic [IdxW+1:0]   nib_lsb;
  logic              last_nib;
  logic              accept;

  assign nib_lsb  = {idx_q, 2'b00};
  assign last_nib = (idx_q == IdxW'(NIBBLES - 1));
  assign accept   = (state_q == StIdle) && req_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StRun;
      StRun:   if (last_nib) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = '0;
    alu_m   = 1'b0;
    alu_cnb = 1'b1;
    if (state_q == StRun) begin
      alu_a   = a_q[nib_lsb +: NibbleW];
      alu_b   = b_q[nib_lsb +: NibbleW];
      alu_s   = s_q;
      alu_m   = m_q;
      alu_cnb = carry_q;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_f     = f_q;
  assign rsp_cn4b  = cn4b_q;
  assign rsp_aeb   = rsp_aeb_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      carry_q   <= 1'b1;
      aeb_q     <= 1'b1;
      idx_q     <= '0;
      f_q       <= '0;
      cn4b_q    <= 1'b1;
      rsp_aeb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= req_a;
        b_q     <= req_b;
        s_q     <= req_s;
        m_q     <= req_m;
        carry_q <= req_cnb;
        aeb_q   <= 1'b1;
        idx_q   <= '0;
      end else if (state_q == StRun) begin
        f_q[nib_lsb +: NibbleW] <= alu_f;
        carry_q <= alu_cn4b;
        aeb_q   <= aeb_q & alu_aeb;
        idx_q   <= last_nib ? '0 : idx_q + IdxW'(1);
        // Response flags only move on the final nibble so they hold through RESP.
        if (last_nib) begin
          cn4b_q    <= alu_cn4b;
          rsp_aeb_q <= aeb_q & alu_aeb;
        end
      end
    end
  end

endmodule
